// File: rtl/j1_fetch_if.sv
// Fetch-stage bundle: ROM read port, redirect request and the instruction valid/ready handshake.
// master = fetch unit, slave = ROM/core environment.
interface j1_fetch_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] rom_address;
    logic                  rom_cen;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  insn_valid;
    logic                  insn_ready;
    logic [DATA_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] insn_pc;

    modport master (
        output rom_address, rom_cen, insn_valid, insn, insn_pc,
        input  rom_q, redirect, redirect_pc, insn_ready
    );

    modport slave (
        input  rom_address, rom_cen, insn_valid, insn, insn_pc,
        output rom_q, redirect, redirect_pc, insn_ready
    );
endinterface

// File: rtl/j1_fetch.sv
// J1 instruction fetch/prefetch: PC-driven ROM reads buffered in a small FIFO, flushed on redirect.
// Optional FETCH_BYPASS_EN forwards rom_q straight to the core when the FIFO is empty.
module j1_fetch #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2,
    parameter int RESET_PC   = 0
) (
    input  logic      clock,
    input  logic      reset_n,
    j1_fetch_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = PW + 2;
    localparam logic [OW-1:0]         DEPTH_O    = OW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;
    logic [DATA_WIDTH-1:0] fifo_insn_r [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_r   [DEPTH];
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW:0]           count_r;

    logic                  fifo_empty_s;
    logic                  bypass_s;
    logic                  insn_valid_s;
    logic [DATA_WIDTH-1:0] insn_s;
    logic [ADDR_WIDTH-1:0] insn_pc_s;
    logic                  pop_s;
    logic                  fifo_pop_s;
    logic                  push_s;
    logic [OW-1:0]         occupancy_s;
    logic                  issue_s;

    // Output selection, handshake decode and the issue decision
    always_comb begin
        fifo_empty_s = (count_r == {(PW+1){1'b0}});
`ifdef FETCH_BYPASS_EN
        bypass_s = fifo_empty_s & inflight_r & ~bus.redirect;
`else
        bypass_s = 1'b0;
`endif
        insn_valid_s = ~fifo_empty_s | bypass_s;
        if (bypass_s) begin
            insn_s    = bus.rom_q;
            insn_pc_s = inflight_pc_r;
        end else begin
            insn_s    = fifo_insn_r[rd_ptr_r];
            insn_pc_s = fifo_pc_r[rd_ptr_r];
        end
        // A pop during redirect is discarded along with the rest of the queue
        pop_s       = insn_valid_s & bus.insn_ready & ~bus.redirect;
        fifo_pop_s  = pop_s & ~fifo_empty_s;
        push_s      = inflight_r & ~bus.redirect & ~(bypass_s & pop_s);
        // Counting the word leaving this cycle keeps one issue per cycle under steady ready
        occupancy_s = OW'(count_r) + OW'(inflight_r) - OW'(pop_s);
        issue_s     = reset_n & ~bus.redirect & (occupancy_s < DEPTH_O);
    end

    assign bus.rom_cen     = issue_s;
    assign bus.rom_address = fetch_pc_r;
    assign bus.insn_valid  = insn_valid_s;
    assign bus.insn        = insn_s;
    assign bus.insn_pc     = insn_pc_s;

    // Fetch PC, in-flight tracking and FIFO pointers/occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_r    <= RESET_ADDR;
            inflight_r    <= 1'b0;
            inflight_pc_r <= RESET_ADDR;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {(PW+1){1'b0}};
        end else if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            inflight_r <= 1'b0;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {(PW+1){1'b0}};
        end else begin
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + ADDR_WIDTH'(1);
                inflight_pc_r <= fetch_pc_r;
            end
            inflight_r <= issue_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, fifo_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: returning ROM word captured at the tail together with its address
    always_ff @(posedge clock) begin
        if (reset_n && push_s) begin
            fifo_insn_r[wr_ptr_r] <= bus.rom_q;
            fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end
endmodule

// File: tb/tb_j1_fetch.sv
// Scoreboard bench for j1_fetch: directed phases plus a random ready/redirect phase,
// checked every cycle against a reference model of issue, latency and ordering.
module tb_j1_fetch;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] RESET_ADDR = 12'h000;

    logic clock;
    logic reset_n;

    j1_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    j1_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RESET_PC(0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {~a[3:0], a};
    endfunction

    // Synchronous ROM model with one-cycle latency
    always @(posedge clock) begin
        if (bus.rom_cen === 1'b1) bus.rom_q <= rom_word(bus.rom_address);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected words: every issued, not-yet-delivered fetch address in order
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] m_fetch_pc;
    logic          m_inflight;
    logic          exp_valid;
    logic          exp_cen;
    logic          pop;
    int            fifo_cnt;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("cen_in_reset", 32'(bus.rom_cen), 32'd0);
            exp_q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = RESET_ADDR;
        end else begin
            fifo_cnt  = exp_q.size() - int'(m_inflight);
            exp_valid = (fifo_cnt > 0);
`ifdef FETCH_BYPASS_EN
            exp_valid = exp_valid || (m_inflight && !bus.redirect);
`endif
            chk("insn_valid", 32'(bus.insn_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("insn_pc", 32'(bus.insn_pc), 32'(exp_q[0]));
                chk("insn", 32'(bus.insn), 32'(rom_word(exp_q[0])));
            end
            pop     = exp_valid && bus.insn_ready && !bus.redirect;
            exp_cen = !bus.redirect && ((exp_q.size() - int'(pop)) < DEPTH);
            chk("rom_cen", 32'(bus.rom_cen), 32'(exp_cen));
            if (exp_cen) chk("rom_address", 32'(bus.rom_address), 32'(m_fetch_pc));
            if (bus.redirect) begin
                exp_q.delete();
                m_fetch_pc = bus.redirect_pc;
                m_inflight = 1'b0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (exp_cen) begin
                    exp_q.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 12'd1;
                end
                m_inflight = exp_cen;
            end
        end
    end

    task automatic cyc(input logic rn, input logic rdy, input logic rd, input logic [AW-1:0] rpc);
        @(posedge clock);
        #1;
        reset_n         = rn;
        bus.insn_ready  = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.insn_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 12'h000;
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 12'h000);
        // Streaming with ready held high
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // Stall from reset, then release
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        repeat (8) cyc(1'b1, 1'b0, 1'b0, 12'h000);
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // Redirect with the queue full and a read in flight
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b1, 12'h123);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // PC wrap across the top of the address space
        cyc(1'b1, 1'b1, 1'b1, 12'hFFE);
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // Back-to-back redirects: last one wins
        cyc(1'b1, 1'b1, 1'b1, 12'h050);
        cyc(1'b1, 1'b1, 1'b1, 12'h200);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // One-cycle reset mid-stream with buffered words
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // Redirect while in reset: reset wins
        cyc(1'b0, 1'b1, 1'b1, 12'h777);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        // Random ready and occasional redirects
        for (int i = 0; i < 3000; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), 12'($urandom));
        end
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 12'h000);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
